// File: rtl/psum_drain_sched_pkg.sv
// Shared types and sizing helpers for the psum drain scheduler and its
// address counter chain.
package psum_drain_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    ZERO  = 2'd2,
    ADV   = 2'd3
  } state_t;

  function automatic int clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  // Rows are drained two at a time; an odd row count leaves a single last pair.
  function automatic int pairs_of(input int rows);
    return (rows + 1) / 2;
  endfunction

  localparam int NUM_ROWS_DEF = 5;
  localparam int NUM_PAIRS    = pairs_of(NUM_ROWS_DEF);

endpackage

// File: rtl/ofm_addr_cnt.sv
// col -> pair -> tile_base -> oc counter chain for the psum drain, with
// end-of-tile and end-of-layer detection.
module ofm_addr_cnt
  import psum_drain_sched_pkg::*;
#(
  parameter int NUM_ROWS = NUM_ROWS_DEF,
  parameter int OFM_C    = 1,
  parameter int OFM_H    = 10,
  parameter int OFM_W    = 8,
  parameter int N_PAIRS  = NUM_PAIRS,
  parameter int C_W      = clog2_min1(OFM_C),
  parameter int H_W      = clog2_min1(OFM_H),
  parameter int W_W      = clog2_min1(OFM_W),
  parameter int P_W      = clog2_min1(N_PAIRS)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           step,
  input  logic           adv,
  output logic [W_W-1:0] col,
  output logic [P_W-1:0] pair,
  output logic [H_W:0]   tile_base,
  output logic [C_W-1:0] oc,
  output logic           tile_end,
  output logic           layer_end
);

  logic [W_W-1:0] col_reg;
  logic [P_W-1:0] pair_reg;
  logic [H_W:0]   tile_base_reg;
  logic [C_W-1:0] oc_reg;

  logic last_col;
  logic next_pair_ok;
  logic tile_wrap;
  logic last_oc;

  always_comb begin
    last_col     = (int'(col_reg) == OFM_W - 1);
    // The next pair exists and its first row still lands inside the OFM.
    next_pair_ok = (int'(pair_reg) + 1 < N_PAIRS) &&
                   (int'(tile_base_reg) + 2 * (int'(pair_reg) + 1) < OFM_H);
    tile_wrap    = (int'(tile_base_reg) + NUM_ROWS >= OFM_H);
    last_oc      = (int'(oc_reg) == OFM_C - 1);
  end

  assign tile_end  = last_col && !next_pair_ok;
  assign layer_end = tile_wrap && last_oc;

  always_ff @(posedge clk) begin
    if (rst) begin
      col_reg       <= '0;
      pair_reg      <= '0;
      tile_base_reg <= '0;
      oc_reg        <= '0;
    end else if (step) begin
      if (last_col) begin
        col_reg  <= '0;
        pair_reg <= next_pair_ok ? pair_reg + 1'b1 : '0;
      end else begin
        col_reg <= col_reg + 1'b1;
      end
    end else if (adv) begin
      if (tile_wrap) begin
        tile_base_reg <= '0;
        oc_reg        <= last_oc ? '0 : oc_reg + 1'b1;
      end else begin
        tile_base_reg <= tile_base_reg + (H_W + 1)'(NUM_ROWS);
      end
    end
  end

  assign col       = col_reg;
  assign pair      = pair_reg;
  assign tile_base = tile_base_reg;
  assign oc        = oc_reg;

endmodule

// File: rtl/psum_drain_sched.sv
// Drains the psum row buffers in row pairs onto two output write ports,
// tags each beat with its OFM address, and clears the buffers per tile.
module psum_drain_sched
  import psum_drain_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 25,
  parameter int NUM_ROWS   = NUM_ROWS_DEF,
  parameter int OFM_C      = 1,
  parameter int OFM_H      = 10,
  parameter int OFM_W      = 8,
  parameter int C_W        = clog2_min1(OFM_C),
  parameter int H_W        = clog2_min1(OFM_H),
  parameter int W_W        = clog2_min1(OFM_W)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           tile_start,
  input  logic [NUM_ROWS-1:0]            row_valid,
  input  logic [NUM_ROWS*DATA_WIDTH-1:0] row_data,
  input  logic                           port_ready,
  output logic [NUM_ROWS-1:0]            row_pop,
  output logic [NUM_ROWS-1:0]            p_write_zero,
  output logic [DATA_WIDTH-1:0]          out_port0,
  output logic [DATA_WIDTH-1:0]          out_port1,
  output logic                           port0_valid,
  output logic                           port1_valid,
  output logic [C_W-1:0]                 out_oc,
  output logic [H_W-1:0]                 out_oh,
  output logic [W_W-1:0]                 out_ow,
  output logic                           busy,
  output logic                           layer_done
);

  localparam int N_PAIRS  = pairs_of(NUM_ROWS);
  localparam int P_W      = clog2_min1(N_PAIRS);
  // Index wide enough for rb = NUM_ROWS on an odd last pair; array padded to a power of two.
  localparam int ROW_W    = clog2_min1(NUM_ROWS + 1);
  localparam int ROWS_PAD = 1 << ROW_W;

  state_t state_reg;
  state_t state_next;

  logic           issue;
  logic           zero_now;
  logic           adv;

  logic [W_W-1:0] col;
  logic [P_W-1:0] pair;
  logic [H_W:0]   tile_base;
  logic [C_W-1:0] oc;
  logic           tile_end;
  logic           layer_end;

  logic [DATA_WIDTH-1:0] row_word [ROWS_PAD];
  logic [ROWS_PAD-1:0]   row_valid_pad;
  logic [ROW_W-1:0]      ra;
  logic [ROW_W-1:0]      rb;
  logic                  usable_a;
  logic                  usable_b;
  logic                  pair_ready;

  logic [DATA_WIDTH-1:0] out_port0_reg;
  logic [DATA_WIDTH-1:0] out_port1_reg;
  logic                  port0_valid_reg;
  logic                  port1_valid_reg;
  logic [C_W-1:0]        out_oc_reg;
  logic [H_W-1:0]        out_oh_reg;
  logic [W_W-1:0]        out_ow_reg;
  logic [NUM_ROWS-1:0]   p_write_zero_reg;
  logic                  layer_done_reg;

  ofm_addr_cnt #(
    .NUM_ROWS (NUM_ROWS),
    .OFM_C    (OFM_C),
    .OFM_H    (OFM_H),
    .OFM_W    (OFM_W),
    .N_PAIRS  (N_PAIRS),
    .C_W      (C_W),
    .H_W      (H_W),
    .W_W      (W_W),
    .P_W      (P_W)
  ) u_addr_cnt (
    .clk       (clk),
    .rst       (rst),
    .step      (issue),
    .adv       (adv),
    .col       (col),
    .pair      (pair),
    .tile_base (tile_base),
    .oc        (oc),
    .tile_end  (tile_end),
    .layer_end (layer_end)
  );

  genvar gi;
  generate
    for (gi = 0; gi < ROWS_PAD; gi++) begin : g_word
      if (gi < NUM_ROWS) begin : g_live
        assign row_word[gi] = row_data[gi*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_pad
        assign row_word[gi] = '0;
      end
    end
  endgenerate

  assign row_valid_pad = ROWS_PAD'(row_valid);

  // Rows past the end of the OFM (or past NUM_ROWS) take no part in the issue.
  always_comb begin
    ra         = ROW_W'({pair, 1'b0});
    rb         = ra + 1'b1;
    usable_a   = (int'(ra) < NUM_ROWS) && (int'(tile_base) + int'(ra) < OFM_H);
    usable_b   = (int'(rb) < NUM_ROWS) && (int'(tile_base) + int'(rb) < OFM_H);
    pair_ready = (usable_a || usable_b) &&
                 (!usable_a || row_valid_pad[ra]) &&
                 (!usable_b || row_valid_pad[rb]);
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (tile_start) state_next = DRAIN;
      DRAIN:   if (issue && tile_end) state_next = ZERO;
      ZERO:    state_next = ADV;
      ADV:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    issue    = 1'b0;
    zero_now = 1'b0;
    adv      = 1'b0;
    case (state_reg)
      DRAIN: begin
        busy  = 1'b1;
        issue = !rst && port_ready && pair_ready;
      end
      ZERO: begin
        busy     = 1'b1;
        zero_now = 1'b1;
      end
      ADV: begin
        busy = 1'b1;
        adv  = 1'b1;
      end
      default: ;
    endcase
  end

  generate
    for (gi = 0; gi < NUM_ROWS; gi++) begin : g_pop
      assign row_pop[gi] = issue && ((usable_a && ra == ROW_W'(gi)) ||
                                     (usable_b && rb == ROW_W'(gi)));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      out_port0_reg    <= '0;
      out_port1_reg    <= '0;
      port0_valid_reg  <= 1'b0;
      port1_valid_reg  <= 1'b0;
      out_oc_reg       <= '0;
      out_oh_reg       <= '0;
      out_ow_reg       <= '0;
      p_write_zero_reg <= '0;
      layer_done_reg   <= 1'b0;
    end else begin
      port0_valid_reg  <= issue;
      port1_valid_reg  <= issue && usable_b;
      p_write_zero_reg <= {NUM_ROWS{zero_now}};
      layer_done_reg   <= adv && layer_end;
      if (issue) begin
        out_port0_reg <= row_word[ra];
        out_port1_reg <= usable_b ? row_word[rb] : '0;
        out_oc_reg    <= oc;
        out_oh_reg    <= H_W'(tile_base + (H_W + 1)'(ra));
        out_ow_reg    <= col;
      end
    end
  end

  assign out_port0    = out_port0_reg;
  assign out_port1    = out_port1_reg;
  assign port0_valid  = port0_valid_reg;
  assign port1_valid  = port1_valid_reg;
  assign out_oc       = out_oc_reg;
  assign out_oh       = out_oh_reg;
  assign out_ow       = out_ow_reg;
  assign p_write_zero = p_write_zero_reg;
  assign layer_done   = layer_done_reg;

endmodule

// File: tb/tb_psum_drain_sched.sv
// Directed bench for psum_drain_sched: row buffers modelled as queues,
// expected beats hand-derived from tile base, pair and column.
module tb_psum_drain_sched;

  localparam int DW = 25;
  localparam int NR = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              tile_start;
  logic [NR-1:0]     row_valid;
  logic [NR*DW-1:0]  row_data;
  logic              port_ready;
  logic [NR-1:0]     row_pop;
  logic [NR-1:0]     p_write_zero;
  logic [DW-1:0]     out_port0;
  logic [DW-1:0]     out_port1;
  logic              port0_valid;
  logic              port1_valid;
  logic [0:0]        out_oc;
  logic [3:0]        out_oh;
  logic [2:0]        out_ow;
  logic              busy;
  logic              layer_done;

  always #5 clk = ~clk;

  psum_drain_sched dut (
    .clk          (clk),
    .rst          (rst),
    .tile_start   (tile_start),
    .row_valid    (row_valid),
    .row_data     (row_data),
    .port_ready   (port_ready),
    .row_pop      (row_pop),
    .p_write_zero (p_write_zero),
    .out_port0    (out_port0),
    .out_port1    (out_port1),
    .port0_valid  (port0_valid),
    .port1_valid  (port1_valid),
    .out_oc       (out_oc),
    .out_oh       (out_oh),
    .out_ow       (out_ow),
    .busy         (busy),
    .layer_done   (layer_done)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [DW-1:0] rowq [NR][$];
  logic [NR-1:0] pend_pop = '0;

  int            b_oh[$];
  int            b_ow[$];
  int            b_oc[$];
  int            b_cyc[$];
  logic [DW-1:0] b_d0[$];
  logic [DW-1:0] b_d1[$];
  logic          b_v1[$];
  int            zero_cycles;
  logic [NR-1:0] zero_val;
  int            done_cnt;
  int            pop_cnt;
  int            bad_pop;

  function automatic logic [DW-1:0] wv(input int t, input int r, input int k);
    return DW'(t * 1000 + r * 100 + k + 1);
  endfunction

  task automatic load_tile(input int t);
    for (int r = 0; r < NR; r++) begin
      rowq[r].delete();
      for (int k = 0; k < 8; k++) rowq[r].push_back(wv(t, r, k));
    end
  endtask

  task automatic clear_log();
    b_oh.delete(); b_ow.delete(); b_oc.delete(); b_cyc.delete();
    b_d0.delete(); b_d1.delete(); b_v1.delete();
    zero_cycles = 0; zero_val = '0; done_cnt = 0; pop_cnt = 0; bad_pop = 0;
  endtask

  // One clock: observe registered outputs, retire last cycle's pops, drive, sample row_pop.
  task automatic step(input logic rdy, input logic [NR-1:0] vmask, input logic start,
                      input logic rst_in);
    @(negedge clk);
    cyc++;
    if (port0_valid === 1'b1) begin
      b_oh.push_back(int'(out_oh)); b_ow.push_back(int'(out_ow));
      b_oc.push_back(int'(out_oc)); b_cyc.push_back(cyc);
      b_d0.push_back(out_port0);
      b_v1.push_back(port1_valid);
      b_d1.push_back(port1_valid ? out_port1 : '0);
    end
    for (int r = 0; r < NR; r++)
      if (pend_pop[r] && rowq[r].size() > 0) void'(rowq[r].pop_front());
    if (p_write_zero !== '0 && p_write_zero !== 'x) begin
      zero_cycles++;
      zero_val = p_write_zero;
      for (int r = 0; r < NR; r++) if (p_write_zero[r]) rowq[r].delete();
    end
    if (layer_done === 1'b1) done_cnt++;
    rst        = rst_in;
    tile_start = start;
    port_ready = rdy;
    for (int r = 0; r < NR; r++) begin
      row_valid[r]          = vmask[r] && (rowq[r].size() > 0);
      row_data[r*DW +: DW]  = (rowq[r].size() > 0) ? rowq[r][0] : '0;
    end
    #1;
    pend_pop = row_pop;
    if (row_pop != '0) pop_cnt++;
    if (row_pop != '0 && !rdy) bad_pop++;
  endtask

  task automatic test_reset();
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    $display("tx reset: busy=%0b valid=%0b%0b", busy, port0_valid, port1_valid);
    n_cmp++;
    if ({port0_valid, port1_valid, layer_done, busy} !== 4'b0) begin
      n_bad++; $display("FAIL rst_flags: got %b want 0000", {port0_valid, port1_valid, layer_done, busy});
    end
    n_cmp++;
    if ({out_port0, out_port1} !== '0) begin
      n_bad++; $display("FAIL rst_data: got %h/%h want 0/0", out_port0, out_port1);
    end
    n_cmp++;
    if ({out_oc, out_oh, out_ow, p_write_zero, row_pop} !== '0) begin
      n_bad++; $display("FAIL rst_addr: got oc%0d oh%0d ow%0d wz%b pop%b want all 0",
                        out_oc, out_oh, out_ow, p_write_zero, row_pop);
    end
  endtask

  task automatic test_single_tile();
    clear_log(); load_tile(1);
    step(1'b1, '1, 1'b1, 1'b0);
    repeat (30) step(1'b1, '1, 1'b0, 1'b0);
    $display("tx single_tile: beats=%0d zero_cycles=%0d", b_oh.size(), zero_cycles);
    n_cmp++;
    if (b_oh.size() != 24) begin n_bad++; $display("FAIL t1_beats: got %0d want 24", b_oh.size()); end
    for (int i = 0; i < b_oh.size() && i < 24; i++) begin
      int p; int k;
      p = i / 8; k = i % 8;
      n_cmp++;
      if (b_oh[i] != 2 * p || b_ow[i] != k || b_oc[i] != 0) begin
        n_bad++; $display("FAIL t1_addr[%0d]: got oc%0d oh%0d ow%0d want oc0 oh%0d ow%0d", i, b_oc[i], b_oh[i], b_ow[i], 2 * p, k);
      end
      n_cmp++;
      if (b_d0[i] !== wv(1, 2 * p, k)) begin
        n_bad++; $display("FAIL t1_d0[%0d]: got %0d want %0d", i, b_d0[i], wv(1, 2 * p, k));
      end
      n_cmp++;
      if (b_v1[i] !== (p < 2)) begin
        n_bad++; $display("FAIL t1_v1[%0d]: got %b want %b", i, b_v1[i], (p < 2));
      end
      if (p < 2) begin
        n_cmp++;
        if (b_d1[i] !== wv(1, 2 * p + 1, k)) begin
          n_bad++; $display("FAIL t1_d1[%0d]: got %0d want %0d", i, b_d1[i], wv(1, 2 * p + 1, k));
        end
      end
    end
    if (b_cyc.size() == 24) begin
      n_cmp++;
      if (b_cyc[23] - b_cyc[0] != 23) begin
        n_bad++; $display("FAIL t1_span: got %0d want 23", b_cyc[23] - b_cyc[0]);
      end
    end
    n_cmp++;
    if (zero_cycles != 1 || zero_val !== 5'b11111) begin
      n_bad++; $display("FAIL t1_zero: got %0d cycles %b want 1 cycles 11111", zero_cycles, zero_val);
    end
    n_cmp++;
    if (done_cnt != 0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL t1_done: got done=%0d busy=%b want done=0 busy=0", done_cnt, busy);
    end
  endtask

  task automatic test_last_tile();
    clear_log(); load_tile(2);
    step(1'b1, '1, 1'b1, 1'b0);
    repeat (30) step(1'b1, '1, 1'b0, 1'b0);
    $display("tx last_tile: beats=%0d layer_done=%0d", b_oh.size(), done_cnt);
    n_cmp++;
    if (b_oh.size() != 24) begin n_bad++; $display("FAIL t2_beats: got %0d want 24", b_oh.size()); end
    for (int i = 0; i < b_oh.size() && i < 24; i++) begin
      int p; int k;
      p = i / 8; k = i % 8;
      n_cmp++;
      if (b_oh[i] != 5 + 2 * p || b_ow[i] != k || b_d0[i] !== wv(2, 2 * p, k)) begin
        n_bad++; $display("FAIL t2_beat[%0d]: got oh%0d ow%0d d%0d want oh%0d ow%0d d%0d",
                          i, b_oh[i], b_ow[i], b_d0[i], 5 + 2 * p, k, wv(2, 2 * p, k));
      end
      n_cmp++;
      if (b_v1[i] !== (p < 2)) begin
        n_bad++; $display("FAIL t2_v1[%0d]: got %b want %b", i, b_v1[i], (p < 2));
      end
    end
    n_cmp++;
    if (done_cnt != 1) begin n_bad++; $display("FAIL t2_layer_done: got %0d pulses want 1", done_cnt); end
    n_cmp++;
    if (zero_cycles != 1) begin n_bad++; $display("FAIL t2_zero: got %0d want 1", zero_cycles); end
  endtask

  task automatic test_ready_toggle();
    clear_log(); load_tile(3);
    step(1'b1, '1, 1'b1, 1'b0);
    for (int i = 0; i < 60; i++) step((i % 2) == 0, '1, 1'b0, 1'b0);
    $display("tx ready_toggle: beats=%0d", b_oh.size());
    n_cmp++;
    if (b_oh.size() != 24) begin n_bad++; $display("FAIL t3_beats: got %0d want 24", b_oh.size()); end
    for (int i = 0; i < b_oh.size() && i < 24; i++) begin
      n_cmp++;
      if (b_ow[i] != i % 8 || b_oh[i] != 2 * (i / 8) || b_oc[i] != 0 || b_d0[i] !== wv(3, 2 * (i / 8), i % 8)) begin
        n_bad++; $display("FAIL t3_beat[%0d]: got oc%0d oh%0d ow%0d d%0d want oc0 oh%0d ow%0d d%0d",
                          i, b_oc[i], b_oh[i], b_ow[i], b_d0[i], 2 * (i / 8), i % 8, wv(3, 2 * (i / 8), i % 8));
      end
      if (i > 0) begin
        n_cmp++;
        if (b_cyc[i] - b_cyc[i-1] != 2) begin
          n_bad++; $display("FAIL t3_gap[%0d]: got %0d want 2", i, b_cyc[i] - b_cyc[i-1]);
        end
      end
    end
    n_cmp++;
    if (bad_pop != 0) begin n_bad++; $display("FAIL t3_pop_not_ready: got %0d want 0", bad_pop); end
  endtask

  task automatic test_row_stall();
    clear_log(); load_tile(4);
    step(1'b1, '1, 1'b1, 1'b0);
    repeat (5) step(1'b1, 5'b11101, 1'b0, 1'b0);
    n_cmp++;
    if (pop_cnt != 0) begin n_bad++; $display("FAIL t4_stall_pop: got %0d pops want 0", pop_cnt); end
    repeat (35) step(1'b1, '1, 1'b0, 1'b0);
    $display("tx row_stall: beats=%0d", b_oh.size());
    n_cmp++;
    if (b_oh.size() != 24) begin n_bad++; $display("FAIL t4_beats: got %0d want 24", b_oh.size()); end
    for (int i = 0; i < b_oh.size() && i < 24; i++) begin
      int p; int k;
      p = i / 8; k = i % 8;
      n_cmp++;
      if (b_oh[i] != 5 + 2 * p || b_ow[i] != k || b_d0[i] !== wv(4, 2 * p, k)) begin
        n_bad++; $display("FAIL t4_beat[%0d]: got oh%0d ow%0d d%0d want oh%0d ow%0d d%0d",
                          i, b_oh[i], b_ow[i], b_d0[i], 5 + 2 * p, k, wv(4, 2 * p, k));
      end
      if (p < 2) begin
        n_cmp++;
        if (b_d1[i] !== wv(4, 2 * p + 1, k)) begin
          n_bad++; $display("FAIL t4_d1[%0d]: got %0d want %0d", i, b_d1[i], wv(4, 2 * p + 1, k));
        end
      end
    end
  endtask

  task automatic test_start_ignored();
    clear_log(); load_tile(5);
    step(1'b1, '1, 1'b1, 1'b0);
    repeat (4) step(1'b1, '1, 1'b0, 1'b0);
    step(1'b1, '1, 1'b1, 1'b0);
    repeat (30) step(1'b1, '1, 1'b0, 1'b0);
    $display("tx start_ignored: beats=%0d", b_oh.size());
    n_cmp++;
    if (b_oh.size() != 24) begin n_bad++; $display("FAIL t5_beats: got %0d want 24", b_oh.size()); end
    for (int i = 0; i < b_oh.size() && i < 24; i++) begin
      n_cmp++;
      if (b_ow[i] != i % 8 || b_oh[i] != 2 * (i / 8)) begin
        n_bad++; $display("FAIL t5_addr[%0d]: got oh%0d ow%0d want oh%0d ow%0d", i, b_oh[i], b_ow[i], 2 * (i / 8), i % 8);
      end
    end
    n_cmp++;
    if (zero_cycles != 1 || done_cnt != 0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL t5_end: got zero=%0d done=%0d busy=%b want 1 0 0", zero_cycles, done_cnt, busy);
    end
  endtask

  task automatic test_reset_mid_drain();
    int guard;
    clear_log(); load_tile(6);
    step(1'b1, '1, 1'b1, 1'b0);
    guard = 0;
    while (pop_cnt < 11 && guard < 40) begin
      step(1'b1, '1, 1'b0, 1'b0);
      guard++;
    end
    n_cmp++;
    if (pop_cnt != 11) begin n_bad++; $display("FAIL t6_reach_col3: got %0d pops want 11", pop_cnt); end
    n_cmp++;
    if (b_ow.size() == 0 || b_ow[b_ow.size()-1] != 1) begin
      n_bad++; $display("FAIL t6_pre_ow: got %0d beats want last ow 1", b_ow.size());
    end
    step(1'b1, '1, 1'b0, 1'b1);
    n_cmp++;
    if (pend_pop !== '0) begin n_bad++; $display("FAIL t6_pop_in_rst: got %b want 00000", pend_pop); end
    for (int r = 0; r < NR; r++) rowq[r].delete();
    step(1'b1, '1, 1'b0, 1'b0);
    $display("tx reset_mid_drain: busy=%0b valid=%0b%0b", busy, port0_valid, port1_valid);
    n_cmp++;
    if ({port0_valid, port1_valid, layer_done, busy, p_write_zero} !== '0 ||
        {out_port0, out_port1, out_oc, out_oh, out_ow} !== '0) begin
      n_bad++; $display("FAIL t6_outputs: got v%b%b d%0d/%0d oh%0d ow%0d busy%b want all 0",
                        port0_valid, port1_valid, out_port0, out_port1, out_oh, out_ow, busy);
    end
    clear_log(); load_tile(7);
    step(1'b1, '1, 1'b1, 1'b0);
    repeat (30) step(1'b1, '1, 1'b0, 1'b0);
    $display("tx restart: beats=%0d", b_oh.size());
    n_cmp++;
    if (b_oh.size() != 24) begin n_bad++; $display("FAIL t6_restart_beats: got %0d want 24", b_oh.size()); end
    if (b_oh.size() > 0) begin
      n_cmp++;
      if (b_oh[0] != 0 || b_ow[0] != 0 || b_d0[0] !== wv(7, 0, 0)) begin
        n_bad++; $display("FAIL t6_restart_first: got oh%0d ow%0d d%0d want oh0 ow0 d%0d", b_oh[0], b_ow[0], b_d0[0], wv(7, 0, 0));
      end
    end
  endtask

  initial begin
    rst = 1'b1; tile_start = 1'b0; port_ready = 1'b0; row_valid = '0; row_data = '0;
    test_reset();
    test_single_tile();
    test_last_tile();
    test_ready_toggle();
    test_row_stall();
    test_start_ignored();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/psum_drain_sched.md
Name: psum_drain_sched

Overview:
- Scheduler that drains the NUM_ROWS partial-sum row buffers onto the two output write ports after each filter pass.
- Pairs rows onto port0/port1, generates the OFM (oc, oh, ow) write address, and clears the buffers when a tile is done.
- Sits between the psum row buffers and the output memory interface, in place of the free-running write-back drain.

Parameters:
- DATA_WIDTH, 25, width of one psum word.
- NUM_ROWS, 5, number of psum row buffers per tile (output rows produced per pass).
- OFM_C, 1, output channels per layer.
- OFM_H, 10, output rows per channel.
- OFM_W, 8, output columns; also the words drained per row.
- C_W / H_W / W_W, clog2 of OFM_C / OFM_H / OFM_W (minimum 1), address field widths.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- tile_start  in  1  pulse: the filter pass for the current tile has ended and the buffers hold final sums
- row_valid  in  NUM_ROWS  per-row buffer has a word at its head
- row_data  in  NUM_ROWS*DATA_WIDTH  packed head words; row r at [r*DATA_WIDTH +: DATA_WIDTH]
- port_ready  in  1  output memory can accept a beat on the next cycle
- row_pop  out  NUM_ROWS  per-row pop strobe, combinational
- p_write_zero  out  NUM_ROWS  per-row buffer clear strobe, registered
- out_port0 / out_port1  out  DATA_WIDTH  output data, registered
- port0_valid / port1_valid  out  1  output beat valid, registered
- out_oc / out_oh / out_ow  out  C_W/H_W/W_W  address of the port0 beat; port1 is always row out_oh+1
- busy  out  1  high in any state other than IDLE
- layer_done  out  1  one-cycle pulse after the last tile of the last channel is cleared

Behaviour:
- Reset: state IDLE. Counters oc=0, tile_base=0, pair=0, col=0. All outputs 0.
- States:
  - IDLE: on tile_start, go to DRAIN. tile_start is ignored in every other state.
  - DRAIN: pairs are rows (0,1), (2,3), …; the last pair is single when the row count is odd.
    - Active rows for the current pair: ra = 2*pair and rb = ra+1.
    - A row is usable only when tile_base+row < OFM_H. Rows past OFM_H are skipped entirely: they are never popped, and they are cleared with the rest in ZERO.
  - Issue condition for a pair: port_ready, and row_valid of every usable row in the pair.
    - On issue, pulse row_pop on those rows in the same cycle.
    - Next cycle: out_port0 = data(ra), port0_valid = 1.
    - If rb is usable: out_port1 = data(rb), port1_valid = 1.
    - out_oc = oc, out_oh = tile_base+ra, out_ow = col.
    - Latency from pop to valid is 1 cycle. Valids are 0 on non-issue cycles. Downstream must accept every valid beat.
  - Column/pair stepping:
    - col increments on each issue.
    - At col = OFM_W-1 with an issue: col wraps to 0 and pair increments.
    - When the next pair has no usable row, or pair reaches ceil(NUM_ROWS/2), go to ZERO.
  - ZERO: assert p_write_zero on all NUM_ROWS for exactly 1 cycle, then go to ADV.
  - ADV (1 cycle):
    - tile_base += NUM_ROWS.
    - If tile_base+NUM_ROWS >= OFM_H: tile_base = 0 and oc increments.
    - If oc was OFM_C-1: oc = 0, pulse layer_done. Pulse and wrap happen in the same cycle.
    - Return to IDLE.
- No partial pops: a pair never pops one row without the other.
- Stall: port_ready low, or a missing row_valid, holds all counters and produces no pop.
- rst mid-DRAIN: abandons the tile immediately, with no pop and no clear. The buffers' own reset handles their contents.
- Widths: no arithmetic on data; data is passed through unchanged. tile_base is H_W+1 bits to hold the overflow compare.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, DRAIN, ZERO, ADV);
  - the NUM_PAIRS = (NUM_ROWS+1)/2 constant;
  - the clog2 width helpers.
- One sub-module, ofm_addr_cnt: the col/pair/tile_base/oc counter chain with wrap and layer-end detection.
- Pair muxing and issue logic stay in the top module.

Test Plan:
- Defaults, all rows hold 8 words, port_ready=1, one tile_start: 8 port0/port1 beats for each of pairs 0 and 1, then 8 port0-only beats for row 4 (24 cycles). Out_oh sequence is 0, 2, 4. p_write_zero = 5'b11111 for 1 cycle. layer_done stays 0.
- Second tile_start: out_oh sequence is 5, 7, 9. Row 9 has port1_valid = 0 (row 10 ≥ OFM_H). Then layer_done pulses once and oc wraps to 0.
- port_ready toggles 1,0,1,0: issues only on ready cycles. out_ow is contiguous 0..7 with no duplicates. Total drain takes 48 cycles.
- row_valid[1] held low for 5 cycles while row 0 is valid: no pop on row 0 or row 1 during those cycles. Draining resumes with data order intact.
- tile_start asserted during DRAIN: ignored, and the counters are unchanged.
- rst asserted at col=3 of pair 1: next cycle all outputs are 0 and state is IDLE. The next tile_start restarts at oh=0, ow=0.
